processador_cpu: RTL and testbench

//   8-bit stack-machine CPU top: control FSM, program ROM, data RAM, 8-bit ALU and LIFO operand stack.

---
 rtl/processador_cpu.sv | 261 ++++++++++++++++++++++++++
 tb/tb_processador_cpu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/processador_cpu.sv
// 8-bit stack-machine CPU: control FSM, program ROM, data RAM, ALU and LIFO operand stack.
// Arithmetic pops TOS into in1 and next into in2, computes in1 op in2 and pushes the result.
module processador_cpu #(
  parameter int STACK_DEPTH = 16,
  parameter int PROG_AW     = 8,
  parameter int RAM_AW      = 8,
  parameter     PROG_FILE   = "prog.hex"
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] temp1,
  output logic [7:0] q_ram_values,
  output logic       carryOut,
  output logic       empty,
  output logic       full
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_PUSHI = 8'h01;
  localparam logic [7:0] OP_PUSHM = 8'h02;
  localparam logic [7:0] OP_POPM  = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h10;
  localparam logic [7:0] OP_SUB   = 8'h11;
  localparam logic [7:0] OP_MUL   = 8'h12;
  localparam logic [7:0] OP_DIV   = 8'h13;
  localparam logic [7:0] OP_JMP   = 8'h20;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_POP_A,
    S_POP_B,
    S_EXECUTE,
    S_PUSH,
    S_MEM_READ,
    S_MEM_WRITE,
    S_HALT
  } state_t;

  // The program image named by PROG_FILE is placed into r_rom by the loading flow.
  if (PROG_FILE == "") begin : g_rom_external
  end

  logic [15:0]      r_rom   [0:(2**PROG_AW)-1];
  logic [7:0]       r_ram   [0:(2**RAM_AW)-1];
  logic [7:0]       r_stack [0:STACK_DEPTH-1];

  state_t           r_state;
  state_t           w_next_state;
  logic [PROG_AW-1:0] r_pc;
  logic [15:0]      r_ir;
  logic [SP_W-1:0]  r_sp;
  logic [7:0]       r_in1;
  logic [7:0]       r_in2;
  logic [7:0]       r_result;
  logic             r_carry;
  logic [7:0]       r_q_ram;

  logic [7:0]       w_opcode;
  logic [7:0]       w_operand;
  logic [SP_W-1:0]  w_sp_m1;
  logic [7:0]       w_tos;
  logic             w_empty;
  logic             w_full;
  logic [7:0]       w_push_data;

  logic             w_fetch;
  logic             w_jump;
  logic             w_pop_a;
  logic             w_pop_b;
  logic             w_exec;
  logic             w_push;
  logic             w_ram_rd;
  logic             w_ram_wr;

  logic [8:0]       w_sum9;
  logic [7:0]       w_diff;
  logic [7:0]       w_prod;
  logic [7:0]       w_quot;
  logic [7:0]       w_alu_res;
  logic             w_alu_carry;
  logic             w_alu_carry_en;

  assign w_opcode  = r_ir[15:8];
  assign w_operand = r_ir[7:0];
  assign w_sp_m1   = r_sp - SP_W'(1);
  assign w_empty   = (r_sp == {SP_W{1'b0}});
  assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
  // An empty stack reads as zero so pops on empty behave like popping 0.
  assign w_tos     = w_empty ? 8'h00 : r_stack[w_sp_m1[IDX_W-1:0]];

  assign temp1        = w_tos;
  assign empty        = w_empty;
  assign full         = w_full;
  assign carryOut     = r_carry;
  assign q_ram_values = r_q_ram;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state and per-state control strobes
  always_comb begin
    w_next_state = r_state;
    w_fetch      = 1'b0;
    w_jump       = 1'b0;
    w_pop_a      = 1'b0;
    w_pop_b      = 1'b0;
    w_exec       = 1'b0;
    w_push       = 1'b0;
    w_ram_rd     = 1'b0;
    w_ram_wr     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_fetch      = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        case (w_opcode)
          OP_NOP:   w_next_state = S_FETCH;
          OP_PUSHI: w_next_state = S_PUSH;
          OP_PUSHM: w_next_state = S_MEM_READ;
          OP_POPM:  w_next_state = S_MEM_WRITE;
          OP_ADD, OP_SUB, OP_MUL, OP_DIV: w_next_state = S_POP_A;
          OP_JMP: begin
            w_jump       = 1'b1;
            w_next_state = S_FETCH;
          end
          OP_HALT:  w_next_state = S_HALT;
          default:  w_next_state = S_FETCH;
        endcase
      end
      S_POP_A: begin
        w_pop_a      = 1'b1;
        w_next_state = S_POP_B;
      end
      S_POP_B: begin
        w_pop_b      = 1'b1;
        w_next_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        w_exec       = 1'b1;
        w_next_state = S_PUSH;
      end
      S_PUSH: begin
        w_push       = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEM_READ: begin
        w_ram_rd     = 1'b1;
        w_next_state = S_PUSH;
      end
      S_MEM_WRITE: begin
        w_ram_wr     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  // ALU: 8-bit two's complement; low byte of a product is sign-independent
  always_comb begin
    w_sum9         = {1'b0, r_in1} + {1'b0, r_in2};
    w_diff         = r_in1 - r_in2;
    w_prod         = r_in1 * r_in2;
    w_quot         = (r_in2 == 8'h00) ? 8'h00 : 8'($signed(r_in1) / $signed(r_in2));
    w_alu_res      = 8'h00;
    w_alu_carry    = 1'b0;
    w_alu_carry_en = 1'b0;
    case (w_opcode)
      OP_ADD: begin
        w_alu_res      = w_sum9[7:0];
        w_alu_carry    = w_sum9[8];
        w_alu_carry_en = 1'b1;
      end
      OP_SUB: begin
        w_alu_res      = w_diff;
        w_alu_carry    = (r_in1 < r_in2);
        w_alu_carry_en = 1'b1;
      end
      OP_MUL:  w_alu_res = w_prod;
      OP_DIV:  w_alu_res = w_quot;
      default: w_alu_res = 8'h00;
    endcase
  end

  // Source of the value written by PUSH_TO_STACK
  always_comb begin
    w_push_data = r_result;
    case (w_opcode)
      OP_PUSHI: w_push_data = w_operand;
      OP_PUSHM: w_push_data = r_q_ram;
      default:  w_push_data = r_result;
    endcase
  end

  // Datapath registers: pc, ir, stack index, ALU operands/result, carry, RAM read data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= {PROG_AW{1'b0}};
      r_ir     <= 16'h0000;
      r_sp     <= {SP_W{1'b0}};
      r_in1    <= 8'h00;
      r_in2    <= 8'h00;
      r_result <= 8'h00;
      r_carry  <= 1'b0;
      r_q_ram  <= 8'h00;
    end else begin
      if (w_fetch) begin
        r_ir <= r_rom[r_pc];
        r_pc <= r_pc + PROG_AW'(1);
      end else if (w_jump) begin
        r_pc <= w_operand[PROG_AW-1:0];
      end
      if (w_pop_a) begin
        r_in1 <= w_tos;
      end
      if (w_pop_b) begin
        r_in2 <= w_tos;
      end
      // Index saturates: no pop below 0, no push beyond STACK_DEPTH.
      if ((w_pop_a || w_pop_b || w_ram_wr) && !w_empty) begin
        r_sp <= w_sp_m1;
      end else if (w_push && !w_full) begin
        r_sp <= r_sp + SP_W'(1);
      end
      if (w_exec) begin
        r_result <= w_alu_res;
        if (w_alu_carry_en) begin
          r_carry <= w_alu_carry;
        end
      end
      if (w_ram_rd) begin
        r_q_ram <= r_ram[w_operand[RAM_AW-1:0]];
      end else if (w_ram_wr) begin
        r_q_ram <= w_tos;
      end
    end
  end

  // Stack and data RAM storage; neither is cleared by reset
  always_ff @(posedge clk) begin
    if (!reset && w_push && !w_full) begin
      r_stack[r_sp[IDX_W-1:0]] <= w_push_data;
    end
    if (!reset && w_ram_wr) begin
      r_ram[w_operand[RAM_AW-1:0]] <= w_tos;
    end
  end

endmodule

// File: tb/tb_processador_cpu.sv
// Directed bench for processador_cpu: table of small programs with hand-computed
// final state, plus hand-written reset/RAM-retention/HALT sequences.
module tb_processador_cpu;

  localparam logic [7:0] OP_PUSHI = 8'h01;
  localparam logic [7:0] OP_PUSHM = 8'h02;
  localparam logic [7:0] OP_POPM  = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h10;
  localparam logic [7:0] OP_SUB   = 8'h11;
  localparam logic [7:0] OP_MUL   = 8'h12;
  localparam logic [7:0] OP_DIV   = 8'h13;
  localparam logic [7:0] OP_JMP   = 8'h20;
  localparam logic [15:0] HALT_W  = 16'hFF00;
  localparam int NV    = 17;
  localparam int PLEN  = 24;
  localparam int RUN_CYCLES = 120;

  typedef struct packed {
    logic [PLEN-1:0][15:0] prog;
    logic [7:0] tos;
    logic [7:0] q;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       carry;
    logic       emp;
    logic       ful;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] temp1;
  logic [7:0] q_ram_values;
  logic       carryOut;
  logic       empty;
  logic       full;

  int tests_run = 0;
  int tests_failed = 0;
  vec_t vecs [NV];
  logic [PLEN-1:0][15:0] hp;

  processador_cpu dut (
    .clk          (clk),
    .reset        (reset),
    .temp1        (temp1),
    .q_ram_values (q_ram_values),
    .carryOut     (carryOut),
    .empty        (empty),
    .full         (full)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ins(input logic [7:0] op, input logic [7:0] arg);
    return {op, arg};
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic load_rom(input logic [PLEN-1:0][15:0] prog);
    for (int a = 0; a < 256; a++) begin
      dut.r_rom[a] = (a < PLEN) ? prog[a] : HALT_W;
    end
  endtask

  task automatic restart();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_exp(input int i, input logic [7:0] tos, input logic [7:0] q,
                         input logic [7:0] in1, input logic [7:0] in2,
                         input logic c, input logic e, input logic f);
    vecs[i].tos = tos; vecs[i].q = q; vecs[i].in1 = in1; vecs[i].in2 = in2;
    vecs[i].carry = c; vecs[i].emp = e; vecs[i].ful = f;
  endtask

  initial begin
    for (int i = 0; i < NV; i++) begin
      vecs[i] = '0;
      for (int j = 0; j < PLEN; j++) vecs[i].prog[j] = HALT_W;
    end
    // 0..3: chained arithmetic 7+2, *3, 54/, 8-
    for (int i = 0; i < 4; i++) begin
      vecs[i].prog[0] = ins(OP_PUSHI, 8'd7);
      vecs[i].prog[1] = ins(OP_PUSHI, 8'd2);
      vecs[i].prog[2] = ins(OP_ADD, 8'h00);
    end
    for (int i = 1; i < 4; i++) begin
      vecs[i].prog[3] = ins(OP_PUSHI, 8'd3);
      vecs[i].prog[4] = ins(OP_MUL, 8'h00);
    end
    for (int i = 2; i < 4; i++) begin
      vecs[i].prog[5] = ins(OP_PUSHI, 8'd54);
      vecs[i].prog[6] = ins(OP_DIV, 8'h00);
    end
    vecs[3].prog[7] = ins(OP_PUSHI, 8'd8);
    vecs[3].prog[8] = ins(OP_SUB, 8'h00);
    set_exp(0, 8'd9,    8'h00, 8'd2,  8'd7,  1'b0, 1'b0, 1'b0);
    set_exp(1, 8'h1B,   8'h00, 8'd3,  8'd9,  1'b0, 1'b0, 1'b0);
    set_exp(2, 8'd2,    8'h00, 8'd54, 8'd27, 1'b0, 1'b0, 1'b0);
    set_exp(3, 8'd6,    8'h00, 8'd8,  8'd2,  1'b0, 1'b0, 1'b0);
    // 4: -18 + 17 = -1
    vecs[4].prog[0] = ins(OP_PUSHI, 8'h11);
    vecs[4].prog[1] = ins(OP_PUSHI, 8'hEE);
    vecs[4].prog[2] = ins(OP_ADD, 8'h00);
    set_exp(4, 8'hFF, 8'h00, 8'hEE, 8'h11, 1'b0, 1'b0, 1'b0);
    // 5: -1 * 18 = -18
    vecs[5].prog[0] = ins(OP_PUSHI, 8'h12);
    vecs[5].prog[1] = ins(OP_PUSHI, 8'hFF);
    vecs[5].prog[2] = ins(OP_MUL, 8'h00);
    set_exp(5, 8'hEE, 8'h00, 8'hFF, 8'h12, 1'b0, 1'b0, 1'b0);
    // 6: 2 / -2 = -1
    vecs[6].prog[0] = ins(OP_PUSHI, 8'hFE);
    vecs[6].prog[1] = ins(OP_PUSHI, 8'h02);
    vecs[6].prog[2] = ins(OP_DIV, 8'h00);
    set_exp(6, 8'hFF, 8'h00, 8'h02, 8'hFE, 1'b0, 1'b0, 1'b0);
    // 7: 4 - 6 = -2 with borrow
    vecs[7].prog[0] = ins(OP_PUSHI, 8'd6);
    vecs[7].prog[1] = ins(OP_PUSHI, 8'd4);
    vecs[7].prog[2] = ins(OP_SUB, 8'h00);
    set_exp(7, 8'hFE, 8'h00, 8'd4, 8'd6, 1'b1, 1'b0, 1'b0);
    // 8: ADD on an empty stack pushes 0
    vecs[8].prog[0] = ins(OP_ADD, 8'h00);
    set_exp(8, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    // 9: 9 / 0 = 0
    vecs[9].prog[0] = ins(OP_PUSHI, 8'd0);
    vecs[9].prog[1] = ins(OP_PUSHI, 8'd9);
    vecs[9].prog[2] = ins(OP_DIV, 8'h00);
    set_exp(9, 8'h00, 8'h00, 8'd9, 8'd0, 1'b0, 1'b0, 1'b0);
    // 10: PUSHI 5, POPM 10, PUSHM 10
    vecs[10].prog[0] = ins(OP_PUSHI, 8'd5);
    vecs[10].prog[1] = ins(OP_POPM, 8'd10);
    vecs[10].prog[2] = ins(OP_PUSHM, 8'd10);
    set_exp(10, 8'd5, 8'd5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    // 11: 0x80 + 0x90 carries out
    vecs[11].prog[0] = ins(OP_PUSHI, 8'h80);
    vecs[11].prog[1] = ins(OP_PUSHI, 8'h90);
    vecs[11].prog[2] = ins(OP_ADD, 8'h00);
    set_exp(11, 8'h10, 8'h00, 8'h90, 8'h80, 1'b1, 1'b0, 1'b0);
    // 12: JMP skips the PUSHI 1 / HALT pair
    vecs[12].prog[0] = ins(OP_JMP, 8'd3);
    vecs[12].prog[1] = ins(OP_PUSHI, 8'd1);
    vecs[12].prog[3] = ins(OP_PUSHI, 8'h42);
    set_exp(12, 8'h42, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    // 13: carry from ADD survives a later MUL
    vecs[13].prog[0] = ins(OP_PUSHI, 8'h80);
    vecs[13].prog[1] = ins(OP_PUSHI, 8'h80);
    vecs[13].prog[2] = ins(OP_ADD, 8'h00);
    vecs[13].prog[3] = ins(OP_PUSHI, 8'd5);
    vecs[13].prog[4] = ins(OP_MUL, 8'h00);
    set_exp(13, 8'h00, 8'h00, 8'd5, 8'h00, 1'b1, 1'b0, 1'b0);
    // 14: 8 - 3 = 5, no borrow
    vecs[14].prog[0] = ins(OP_PUSHI, 8'd3);
    vecs[14].prog[1] = ins(OP_PUSHI, 8'd8);
    vecs[14].prog[2] = ins(OP_SUB, 8'h00);
    set_exp(14, 8'd5, 8'h00, 8'd8, 8'd3, 1'b0, 1'b0, 1'b0);
    // 15: 17 pushes into a 16-deep stack, the 17th is dropped
    for (int j = 0; j < 17; j++) vecs[15].prog[j] = ins(OP_PUSHI, 8'(j + 1));
    set_exp(15, 8'd16, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    // 16: POPM on empty stores 0, read back pushes 0
    vecs[16].prog[0] = ins(OP_POPM, 8'd3);
    vecs[16].prog[1] = ins(OP_PUSHM, 8'd3);
    set_exp(16, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset.temp1", temp1, 8'h00);
    check("reset.q_ram", q_ram_values, 8'h00);
    check("reset.carry", {7'b0, carryOut}, 8'h00);
    check("reset.empty", {7'b0, empty}, 8'h01);
    check("reset.full",  {7'b0, full}, 8'h00);
    check("reset.pc",    dut.r_pc, 8'h00);

    for (int i = 0; i < NV; i++) begin
      load_rom(vecs[i].prog);
      restart();
      repeat (RUN_CYCLES) @(negedge clk);
      check($sformatf("vec%0d.temp1", i), temp1, vecs[i].tos);
      check($sformatf("vec%0d.q_ram", i), q_ram_values, vecs[i].q);
      check($sformatf("vec%0d.in1", i), dut.r_in1, vecs[i].in1);
      check($sformatf("vec%0d.in2", i), dut.r_in2, vecs[i].in2);
      check($sformatf("vec%0d.carry", i), {7'b0, carryOut}, {7'b0, vecs[i].carry});
      check($sformatf("vec%0d.empty", i), {7'b0, empty}, {7'b0, vecs[i].emp});
      check($sformatf("vec%0d.full", i), {7'b0, full}, {7'b0, vecs[i].ful});
    end

    // Reset in the middle of a MUL, then rerun to completion
    for (int j = 0; j < PLEN; j++) hp[j] = HALT_W;
    hp[0] = ins(OP_PUSHI, 8'd3);
    hp[1] = ins(OP_PUSHI, 8'd4);
    hp[2] = ins(OP_MUL, 8'h00);
    load_rom(hp);
    restart();
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midmul.empty", {7'b0, empty}, 8'h01);
    check("midmul.pc",    dut.r_pc, 8'h00);
    check("midmul.temp1", temp1, 8'h00);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("midmul.rerun_tos", temp1, 8'h0C);
    check("midmul.rerun_in1", dut.r_in1, 8'd4);
    check("midmul.rerun_in2", dut.r_in2, 8'd3);

    // RAM contents survive reset
    for (int j = 0; j < PLEN; j++) hp[j] = HALT_W;
    hp[0] = ins(OP_PUSHI, 8'h5A);
    hp[1] = ins(OP_POPM, 8'd20);
    load_rom(hp);
    restart();
    repeat (20) @(negedge clk);
    check("ramkeep.empty_after_popm", {7'b0, empty}, 8'h01);
    hp[0] = ins(OP_PUSHM, 8'd20);
    hp[1] = HALT_W;
    load_rom(hp);
    restart();
    repeat (20) @(negedge clk);
    check("ramkeep.temp1", temp1, 8'h5A);
    check("ramkeep.q_ram", q_ram_values, 8'h5A);

    // HALT is terminal: pc stops one past the HALT word
    for (int j = 0; j < PLEN; j++) hp[j] = HALT_W;
    load_rom(hp);
    restart();
    repeat (30) @(negedge clk);
    check("halt.pc",    dut.r_pc, 8'h01);
    check("halt.empty", {7'b0, empty}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
